// File: rtl/codifica_hamming_pkg.sv
// Shared constants for the Hamming(15,11) encoder:
// codeword layout, parity coverage masks and word widths.
package codifica_hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;

  localparam logic [3:0] P0_IDX = 4'd14;
  localparam logic [3:0] P1_IDX = 4'd13;
  localparam logic [3:0] P2_IDX = 4'd11;
  localparam logic [3:0] P3_IDX = 4'd7;

  // codeword bit that carries dado[i]
  localparam logic [3:0] DATA_IDX [DATA_W] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
    4'd6, 4'd8, 4'd9, 4'd10, 4'd12
  };

  localparam logic [CODE_W-1:0] P0_MASK = 15'h1555;
  localparam logic [CODE_W-1:0] P1_MASK = 15'h1333;
  localparam logic [CODE_W-1:0] P2_MASK = 15'h070F;
  localparam logic [CODE_W-1:0] P3_MASK = 15'h007F;

endpackage

// File: rtl/codifica_hamming_paridade.sv
// Combinational Hamming(15,11) mapper: places data bits
// and computes the four parity bits.
module codifica_hamming_paridade
  import codifica_hamming_pkg::*;
(
  input  logic [DATA_W-1:0] dado,
  output logic [CODE_W-1:0] codigo
);

  logic [CODE_W-1:0] data_c;

  always_comb begin
    data_c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data_c[DATA_IDX[i]] = dado[i];
    end
  end

  always_comb begin
    codigo = data_c;
    codigo[P0_IDX] = ^(data_c & P0_MASK);
    codigo[P1_IDX] = ^(data_c & P1_MASK);
    codigo[P2_IDX] = ^(data_c & P2_MASK);
    codigo[P3_IDX] = ^(data_c & P3_MASK);
  end

endmodule

// File: rtl/codifica_hamming.sv
// Streaming Hamming(15,11) encoder with 2-entry skid buffer,
// one-shot error injection and accepted-word counter.
module codifica_hamming
  import codifica_hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dado,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] codigo,
  input  logic              inj_arm,
  input  logic [3:0]        inj_pos,
  output logic              inj_pending,
  output logic [CNT_W-1:0]  palavras_cnt
);

  logic [CODE_W-1:0] codigo_q, codigo_d;
  logic [CODE_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              inj_pending_q, inj_pending_d;
  logic [3:0]        inj_pos_q, inj_pos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CODE_W-1:0] enc;
  logic [CODE_W-1:0] word;
  logic [3:0]        pos_eff;
  logic              flip_en;
  logic              in_fire;
  logic              out_fire;

  codifica_hamming_paridade u_paridade (
    .dado   (dado),
    .codigo (enc)
  );

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // an arm in the same cycle as a transfer targets that very word
  assign pos_eff = inj_arm ? inj_pos : inj_pos_q;
  assign flip_en = (inj_arm | inj_pending_q) & (pos_eff != 4'hF);
  assign word    = flip_en
                 ? enc ^ ({{(CODE_W-1){1'b0}}, 1'b1} << pos_eff)
                 : enc;

  always_comb begin
    codigo_d     = codigo_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        codigo_d     = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) skid_d = word;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) codigo_d = word;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_d       = word;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_comb begin
    inj_pending_d = inj_pending_q;
    inj_pos_d     = inj_pos_q;
    cnt_d         = cnt_q;
    if (inj_arm) inj_pos_d = inj_pos;
    if (in_fire) begin
      inj_pending_d = 1'b0;
      cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (inj_arm) begin
      inj_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codigo_q      <= '0;
      skid_q        <= '0;
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      in_ready_q    <= 1'b1;
      inj_pending_q <= 1'b0;
      inj_pos_q     <= 4'hF;
      cnt_q         <= '0;
    end else begin
      codigo_q      <= codigo_d;
      skid_q        <= skid_d;
      out_valid_q   <= out_valid_d;
      skid_valid_q  <= skid_valid_d;
      in_ready_q    <= in_ready_d;
      inj_pending_q <= inj_pending_d;
      inj_pos_q     <= inj_pos_d;
      cnt_q         <= cnt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign codigo       = codigo_q;
  assign inj_pending  = inj_pending_q;
  assign palavras_cnt = cnt_q;

endmodule

// File: tb/tb_codifica_hamming.sv
// Bench for codifica_hamming: FIFO-level reference model,
// directed cases plus randomized traffic and injection.
module tb_codifica_hamming;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] dado = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] codigo;
  logic        inj_arm = 1'b0;
  logic [3:0]  inj_pos = 4'hF;
  logic        inj_pending;
  logic [15:0] palavras_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [14:0] codigo4;
  logic        inj_pending4;
  logic [3:0]  cnt4;

  int total = 0;
  int bad = 0;

  logic [14:0] mq[$];
  logic        m_pend = 1'b0;
  logic [3:0]  m_pos = 4'hF;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  codifica_hamming #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dado(dado),
    .out_valid(out_valid), .out_ready(out_ready),
    .codigo(codigo),
    .inj_arm(inj_arm), .inj_pos(inj_pos),
    .inj_pending(inj_pending),
    .palavras_cnt(palavras_cnt)
  );

  codifica_hamming #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .dado(dado),
    .out_valid(out_valid4), .out_ready(out_ready),
    .codigo(codigo4),
    .inj_arm(inj_arm), .inj_pos(inj_pos),
    .inj_pending(inj_pending4),
    .palavras_cnt(cnt4)
  );

  // classic Hamming positions 1..15; position p lives in codigo[15-p]
  function automatic logic [14:0] ref_enc(input logic [10:0] d);
    logic [15:1] pos;
    logic [14:0] c;
    logic par;
    int k;
    pos = '0;
    k = 10;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos[p] = d[k];
        k--;
      end
    end
    for (int j = 0; j < 4; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 15; p++)
        if ((p & (1 << j)) != 0) par = par ^ pos[p];
      pos[1 << j] = par;
    end
    for (int p = 1; p <= 15; p++) c[15-p] = pos[p];
    return c;
  endfunction

  function automatic int syndrome(input logic [14:0] c);
    int s;
    s = 0;
    for (int b = 0; b < 15; b++)
      if (c[b]) s = s ^ (15 - b);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit inf, outf, pe;
    logic [3:0] p;
    logic [14:0] w;
    inf  = in_valid && (mq.size() < 2);
    outf = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (outf) void'(mq.pop_front());
    if (inf) begin
      pe = inj_arm || m_pend;
      p  = inj_arm ? inj_pos : m_pos;
      w  = ref_enc(dado);
      if (pe && p != 4'hF) w[p] = ~w[p];
      mq.push_back(w);
      m_pend = 1'b0;
      m_cnt++;
    end else if (inj_arm) begin
      m_pend = 1'b1;
      m_pos  = inj_pos;
    end
    #1;
    inj_arm = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("inj_pending", 32'(inj_pending), 32'(m_pend));
    chk("cnt", 32'(palavras_cnt), 32'(m_cnt % 65536));
    chk("cnt4", 32'(cnt4), 32'(m_cnt % 16));
    if (mq.size() > 0) chk("codigo", 32'(codigo), 32'(mq[0]));
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_pos  = 4'hF;
    m_cnt  = 0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_codigo", 32'(codigo), 32'd0);
    chk("rst_inj_pending", 32'(inj_pending), 32'd0);
    chk("rst_cnt", 32'(palavras_cnt), 32'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // single words through an empty pipe
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dado      = 11'h000;
    tick();
    chk("t1_codigo", 32'(codigo), 32'h0000);
    chk("t1_cnt", 32'(palavras_cnt), 32'd1);
    dado = 11'h001;
    tick();
    chk("t2_001", 32'(codigo), 32'h6881);
    dado = 11'h7FF;
    tick();
    chk("t2_7ff", 32'(codigo), 32'h7FFF);

    // sustained stream
    for (int i = 0; i < 100; i++) begin
      dado = 11'($urandom);
      tick();
      chk("stream_syndrome", 32'(syndrome(codigo)), 32'd0);
    end
    in_valid = 1'b0;
    tick();

    // stall: fill output and skid, third word waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dado = 11'h123;
    tick();
    dado = 11'h456;
    tick();
    chk("t3_in_ready_low", 32'(in_ready), 32'd0);
    dado = 11'h789;
    tick();
    chk("t3_hold", 32'(codigo), 32'(ref_enc(11'h123)));
    out_ready = 1'b1;
    tick();
    chk("t3_second", 32'(codigo), 32'(ref_enc(11'h456)));
    tick();
    in_valid = 1'b0;
    chk("t3_third", 32'(codigo), 32'(ref_enc(11'h789)));
    tick();
    tick();

    // injection on bit 0, then an untouched word
    inj_arm = 1'b1;
    inj_pos = 4'd0;
    tick();
    chk("t4_armed", 32'(inj_pending), 32'd1);
    in_valid = 1'b1;
    dado = 11'h001;
    tick();
    chk("t4_flip", 32'(codigo), 32'h6880);
    chk("t4_consumed", 32'(inj_pending), 32'd0);
    tick();
    chk("t4_clean", 32'(codigo), 32'h6881);
    in_valid = 1'b0;
    tick();

    // randomized traffic, back-pressure and injection
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      dado      = 11'($urandom);
      inj_arm   = ($urandom_range(15) == 0);
      inj_pos   = 4'($urandom);
      tick();
    end

    // async reset with both registers full
    in_valid  = 1'b1;
    out_ready = 1'b0;
    inj_arm   = 1'b0;
    tick();
    tick();
    tick();
    chk("t5_full", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_cnt", 32'(palavras_cnt), 32'd0);
    chk("t5_cnt4", 32'(cnt4), 32'd0);
    model_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    tick();
    chk("t5_no_stale", 32'(out_valid), 32'd0);

    // counter wrap on the narrow instance
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dado = 11'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("t6_cnt4_wrap", 32'(cnt4), 32'd1);
    chk("t6_cnt16", 32'(palavras_cnt), 32'd17);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
